// File: rtl/gray_conv_if.sv
// Request/response bundle for the shared binary/Gray converter.
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_data            : requester i operand at [i*N +: N]
//   req_mode            : per-requester direction, 0 = bin->gray, 1 = gray->bin
//   rsp_valid/rsp_ready : result handshake
//   rsp_data/rsp_id     : converted word and owning requester
// master = client side, slave = arbiter side.
interface gray_conv_if #(
  parameter int N = 4
);
  logic [3:0]     req_valid;
  logic [4*N-1:0] req_data;
  logic [3:0]     req_mode;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic [N-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic           rsp_ready;

  modport master (
    output req_valid, req_data, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary/Gray converter among four requesters.
// One transaction in flight: IDLE grants and latches the operand, CONV
// registers the converted word, RESP holds it until rsp_ready.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : gray_conv_if.slave (request and response handshakes)
module gray_conv_arbiter #(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gray_conv_if.slave  bus
);
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t state, state_n;

  logic [1:0]                    rr_ptr;
  logic [NUM_REQ-1:0][N-1:0]     req_word;
  logic [N-1:0]                  op_data;
  logic                          op_mode;
  logic [1:0]                    op_id;
  logic                          rsp_valid_q;
  logic [N-1:0]                  rsp_data_q;
  logic [1:0]                    rsp_id_q;

  logic                          gnt_found;
  logic [1:0]                    gnt_idx;
  logic [1:0]                    cand;
  logic                          accept;
  logic [N-1:0]                  b2g, g2b, conv_res;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = bus.req_data[i*N +: N];
  end

  // Search upward from rr_ptr; the 2-bit add wraps 3 -> 0 naturally.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + 2'(k);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept        = (state == IDLE) && gnt_found;
  // Gated by rst_n so nothing is accepted on an edge where reset wins.
  assign bus.req_ready = (rst_n && accept) ? (4'd1 << gnt_idx) : 4'd0;

  // Gray->binary is a prefix XOR from the MSB down.
  always_comb begin
    b2g = op_data ^ (op_data >> 1);
    g2b = '0;
    g2b[N-1] = op_data[N-1];
    for (int i = N - 2; i >= 0; i--)
      g2b[i] = g2b[i+1] ^ op_data[i];
    conv_res = op_mode ? g2b : b2g;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_found) state_n = CONV;
      CONV:    state_n = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      op_data     <= '0;
      op_mode     <= 1'b0;
      op_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      if (accept) begin
        op_data <= req_word[gnt_idx];
        op_mode <= bus.req_mode[gnt_idx];
        op_id   <= gnt_idx;
      end
      if (state == CONV) begin
        rsp_data_q  <= conv_res;
        rsp_id_q    <= op_id;
        rsp_valid_q <= 1'b1;
      end
      if (state == RESP && rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rr_ptr      <= op_id + 2'd1;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: stimulus tasks drive requests,
// a negedge monitor predicts grants/responses and compares.
module tb_gray_conv_arbiter;
  localparam int N = 4;

  typedef struct {
    logic [1:0]   id;
    logic [N-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_conv_if #(.N(N)) bus ();
  gray_conv_arbiter #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rsp_t q[$];
  rsp_t rlog[$];
  int   glog[$];
  int   acyc[$];
  int   ph      = 0;   // 0 idle, 1 converting, 2 response pending
  int   ptr     = 0;
  bit   post_rst = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   rdy_fixed = 1'b1;

  function automatic logic [N-1:0] ref_b2g(logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the parity of all Gray bits at or above i.
  function automatic logic [N-1:0] ref_g2b(logic [N-1:0] g);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and checker, sampled away from the active edge.
  always @(negedge clk) begin
    int   g;
    logic [3:0] exp_rdy;
    logic [N-1:0] d;
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      q.delete();
      ph = 0; ptr = 0; post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        post_rst = 1'b0;
      end
      g = -1;
      if (ph == 0)
        for (int k = 0; k < 4; k++)
          if (g < 0 && bus.req_valid[(ptr + k) % 4]) g = (ptr + k) % 4;
      exp_rdy = (g >= 0) ? (4'd1 << g) : 4'd0;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("rsp_valid", bus.rsp_valid, (ph == 2) ? 1 : 0);
      case (ph)
        0: if (g >= 0) begin
             d = bus.req_data[g*N +: N];
             q.push_back('{id: 2'(g),
                           data: bus.req_mode[g] ? ref_g2b(d) : ref_b2g(d)});
             glog.push_back(g);
             acyc.push_back(cyc);
             ph = 1;
           end
        1: ph = 2;
        default: begin
          if (bus.rsp_valid) begin
            if (q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
              chk("rsp_data", bus.rsp_data, q[0].data);
              chk("rsp_id", bus.rsp_id, q[0].id);
            end
          end
          if (bus.rsp_ready && q.size() != 0) begin
            rlog.push_back('{id: bus.rsp_id, data: bus.rsp_data});
            ptr = (q[0].id + 1) % 4;
            void'(q.pop_front());
            ph = 0;
          end
        end
      endcase
    end
  end

  // Sole driver of rsp_ready.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = rdy_rand ? 1'($urandom % 2) : rdy_fixed;
    end
  end

  // Raise mask bits; wait for n acceptances. keep=1 re-randomises data of
  // accepted requesters and keeps them valid; otherwise they drop out.
  task automatic burst(logic [3:0] mask, bit keep, int n);
    int to = 0;
    logic [3:0] a;
    bus.req_valid = bus.req_valid | mask;
    while (n > 0 && to < 200) begin
      @(negedge clk);
      a = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      to++;
      if (a != 0) begin
        n--;
        if (!keep) bus.req_valid = bus.req_valid & ~a;
        else
          for (int i = 0; i < 4; i++)
            if (a[i]) bus.req_data[i*N +: N] = N'($urandom);
      end
    end
    if (n > 0) chk("burst_timeout", n, 0);
    bus.req_valid = bus.req_valid & ~mask;
  endtask

  task automatic send(int id, logic [N-1:0] d, bit m);
    bus.req_data[id*N +: N] = d;
    bus.req_mode[id] = m;
    burst(4'd1 << id, 1'b0, 1);
  endtask

  task automatic drain();
    int to = 0;
    while ((ph != 0 || q.size() != 0) && to < 200) begin
      @(posedge clk); #1;
      to++;
    end
    if (to >= 200) chk("drain_timeout", to, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clr_logs();
    rlog.delete(); glog.delete(); acyc.delete();
  endtask

  initial begin
    int exp_g[$];
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_mode  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requests with known answers
    clr_logs();
    send(0, 4'b0101, 1'b0); drain();
    send(2, 4'b0111, 1'b1); drain();
    send(2, 4'b0000, 1'b1); drain();
    chk("dir_cnt", rlog.size(), 3);
    if (rlog.size() == 3) begin
      chk("dir0_data", rlog[0].data, 4'b0111); chk("dir0_id", rlog[0].id, 0);
      chk("dir1_data", rlog[1].data, 4'b0101); chk("dir1_id", rlog[1].id, 2);
      chk("dir2_data", rlog[2].data, 4'b0000);
    end

    // Fairness: all four held valid after reset
    @(posedge clk); #1;
    do_reset();
    clr_logs();
    for (int i = 0; i < 4; i++) bus.req_data[i*N +: N] = N'($urandom);
    bus.req_mode = 4'($urandom);
    burst(4'hf, 1'b1, 5); drain();
    exp_g = '{0, 1, 2, 3, 0};
    chk("fair_cnt", glog.size(), 5);
    if (glog.size() == 5)
      for (int i = 0; i < 5; i++) begin
        chk("fair_order", glog[i], exp_g[i]);
        if (i > 0) chk("fair_spacing", acyc[i] - acyc[i-1], 3);
      end

    // Pointer after requester 2: 3 wins over 0
    send(2, 4'd9, 1'b0); drain();
    clr_logs();
    bus.req_data = 16'h5a3c;
    burst(4'b1001, 1'b0, 2); drain();
    chk("rr_cnt", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("rr_first", glog[0], 3);
      chk("rr_second", glog[1], 0);
    end

    // Backpressure with a competing requester waiting
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    send(1, 4'd6, 1'b0);
    bus.req_data[3*N +: N] = 4'd11;
    bus.req_valid[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1 rdy_fixed = 1'b1;
    burst(4'b1000, 1'b0, 1); drain();

    // Exhaustive both directions plus gray->bin round trip
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 16; v++) send($urandom_range(3, 0), 4'(v), 1'(m));
    for (int v = 0; v < 16; v++) send($urandom_range(3, 0), ref_b2g(4'(v)), 1'b1);
    drain();
    chk("roundtrip_ref", ref_g2b(ref_b2g(4'd13)), 13);

    // Random traffic with random backpressure
    rdy_rand = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.req_valid = 4'($urandom);
      bus.req_data  = 16'($urandom);
      bus.req_mode  = 4'($urandom);
    end
    bus.req_valid = '0;
    rdy_rand = 1'b0;
    drain();

    // Reset during CONV discards the transaction; pointer back to 0
    send(3, 4'd7, 1'b0);
    do_reset();
    repeat (3) @(posedge clk);
    #1 clr_logs();
    burst(4'hf, 1'b0, 1); drain();
    chk("post_rst_grant", (glog.size() > 0) ? glog[0] : -1, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin arbiter and sequencer that shares a single binary/Gray code conversion unit among four requesters. Each requester submits an N-bit word and a direction bit: binary-to-Gray or Gray-to-binary. The block grants one requester at a time, registers the operand, performs the conversion in a dedicated cycle, and holds the result on a valid/ready response port tagged with the requester ID. It sits between the converter library and any clients that need occasional code conversion, such as pointer or encoder logic, so those clients do not each instantiate their own converter.

## Interface
- N, default 4: data width in bits; legal when N >= 2.
- clk  input  1: single clock; all logic is rising-edge.
- rst_n  input  1: synchronous, active-low reset.
- req_valid  input  4: per-requester request strobe; bit i belongs to requester i.
- req_data  input  4*N: operands; requester i uses bits [i*N +: N].
- req_mode  input  4: per-requester direction; 0 = binary-to-Gray, 1 = Gray-to-binary.
- req_ready  output  4: one-hot accept; a request transfers when req_valid[i] and req_ready[i] are both high on a clock edge.
- rsp_valid  output  1: result available.
- rsp_data  output  N: converted word.
- rsp_id  output  2: index of the requester that owns the result.
- rsp_ready  input  1: consumer accepts the result.

## Operation
- The state machine has three states: IDLE, CONV and RESP.
- **IDLE**
  - The grant goes to the first requester with req_valid set, searching from rr_ptr upward and wrapping 3 -> 0.
  - req_ready is combinational: it is one-hot at the granted index and zero when no request is present.
  - On acceptance, the block latches req_data slice, req_mode bit and index, then moves to CONV.
- **CONV**
  - Binary-to-Gray: G[N-1] = B[N-1]; G[i] = B[i] ^ B[i+1] for i < N-1.
  - Gray-to-binary: B[N-1] = G[N-1]; B[i] = B[i+1] ^ G[i], computed from the MSB down.
  - The result is registered into rsp_data, rsp_id is set to the latched index, and rsp_valid is set. The state then moves to RESP.
- **RESP**
  - rsp_valid, rsp_data and rsp_id stay stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid clears, rr_ptr becomes (granted index + 1) mod 4, and the state returns to IDLE.
- req_ready is 0 in CONV and RESP. Only one transaction is ever in flight.
- A requester may drop req_valid before it is granted; no state is kept for ungranted requests.
- req_data and req_mode are sampled only on the accepting edge. Later changes do not affect an in-flight transaction.
- The grant is fair: any requester that holds req_valid high is served within 4 transactions.

## Timing
- **Reset:** while rst_n is low at a clock edge, the state goes to IDLE, rr_ptr = 0, rsp_valid = 0, rsp_data = 0 and rsp_id = 0. req_ready is forced to 0 during the reset cycle.
- **Latency:**
  - Acceptance occurs at edge T.
  - rsp_valid is high after edge T+1 (the CONV edge).
  - If rsp_ready is already high, the response is consumed at edge T+2.
- **Throughput:** at best, one transaction every 3 cycles. A new acceptance can occur at edge T+3 at the earliest, because IDLE evaluates in the cycle after the response handshake.
- **Backpressure:** RESP holds indefinitely and no new grant is issued while rsp_ready is low.
- **Reset mid-operation:** reset in CONV or RESP discards the transaction. No response is produced, and rr_ptr returns to 0.
- **Simultaneous events:**
  - When all four requesters are valid in IDLE, exactly one is granted: rr_ptr first.
  - rsp_ready is ignored when rsp_valid is 0.

## Test plan
- **Single request, binary-to-Gray:** requester 0, data 4'b0101, mode 0, rsp_ready = 1.
  - req_ready[0] is high the same cycle.
  - rsp_valid is high one cycle after acceptance, with rsp_data = 4'b0111 and rsp_id = 0.
- **Single request, Gray-to-binary:** requester 2, data 4'b0111, mode 1.
  - rsp_data = 4'b0101, rsp_id = 2.
  - A second run with data 4'b0000 gives rsp_data = 4'b0000.
- **All-request fairness:** after reset, all four requesters hold req_valid high with rsp_ready = 1.
  - Grants occur in the order 0, 1, 2, 3, 0, spaced 3 cycles apart.
  - rsp_id follows the same sequence.
- **Round-robin pointer:** after requester 2 is served, requesters 0 and 3 both raise req_valid.
  - Requester 3 is granted first, then requester 0.
- **Backpressure:** rsp_ready is held low for 5 cycles while in RESP.
  - rsp_valid, rsp_data and rsp_id stay constant, and req_ready stays 4'b0000.
  - When rsp_ready rises, the handshake completes and IDLE resumes.
- **Exhaustive and reset:**
  - For all 16 values in each mode, the output matches the reference conversion, and a Gray-then-binary round trip returns the input.
  - Asserting rst_n = 0 during CONV gives no rsp_valid and returns the block to the reset values.
